// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
//   Button-driven controller for one add operation on a shared operand bus.
//   Each press of the "enter" key advances the sequence:
//     LOAD_X: pulse load_x, so the external x register captures the bus.
//     LOAD_Y: pulse load_y, so the y register captures the bus, and latch carry_sel.
//     CALC  : wait for the adder to settle, then latch its sum and carry-out.
//     DONE  : show the result. The next press clears result_valid and loads a new X.
//   The raw key is synchronised and then debounced inside this block.
//
// Ports
//   clock           system clock
//   reset           asynchronous, active-high reset
//   key_n           raw active-low push-button
//   carry_sel       switch; sampled as the carry-in during the LOAD_Y press
//   load_x, load_y  one-cycle capture strobes for the external operand registers
//   adder_carry_in  registered carry-in driven to the external adder
//   z_in            adder sum
//   carry_out_in    adder carry-out
//   result          latched sum
//   result_carry    latched carry-out
//   result_valid    result holds a completed operation
//   state           FSM state for LED display (LOAD_X=0, LOAD_Y=1, CALC=2, DONE=3)
module adder_operand_sequencer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_n,
  input  logic             carry_sel,
  output logic             load_x,
  output logic             load_y,
  output logic             adder_carry_in,
  input  logic [WIDTH-1:0] z_in,
  input  logic             carry_out_in,
  output logic [WIDTH-1:0] result,
  output logic             result_carry,
  output logic             result_valid,
  output logic [1:0]       state
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StLoadX = 2'd0,
    StLoadY = 2'd1,
    StCalc  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Key synchroniser, debouncer and press detector
  // ---------------------------------------------------------------------------
  logic            key_meta_q, key_sync_q;
  logic            deb_q, deb_d;
  logic            deb_dly_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            enter_q, enter_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (key_sync_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // The level has now differed for DEBOUNCE_CYCLES consecutive cycles.
      deb_d = key_sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // A press is a debounced 1->0 transition. The edge detector is registered, so
  // the press pulse comes one cycle after the debounced level changes.
  assign enter_d = deb_dly_q & ~deb_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      deb_q      <= 1'b1;
      deb_dly_q  <= 1'b1;
      cnt_q      <= '0;
      enter_q    <= 1'b0;
    end else begin
      key_meta_q <= key_n;
      key_sync_q <= key_meta_q;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      cnt_q      <= cnt_d;
      enter_q    <= enter_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             load_x_q, load_x_d;
  logic             load_y_q, load_y_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_carry_q, result_carry_d;
  logic             result_valid_q, result_valid_d;

  // The state register and the registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StLoadX;
      load_x_q       <= 1'b0;
      load_y_q       <= 1'b0;
      carry_q        <= 1'b0;
      result_q       <= '0;
      result_carry_q <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_x_q       <= load_x_d;
      load_y_q       <= load_y_d;
      carry_q        <= carry_d;
      result_q       <= result_d;
      result_carry_q <= result_carry_d;
      result_valid_q <= result_valid_d;
    end
  end

  // CALC is entered together with the load_y strobe. The y register captures
  // at the end of that strobe cycle, so CALC waits one more cycle for the adder
  // to settle. The result is latched 2 cycles after the strobe cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoadX: if (enter_q) state_d = StLoadY;
      StLoadY: if (enter_q) state_d = StCalc;
      StCalc:  if (!load_y_q) state_d = StDone;
      StDone:  if (enter_q) state_d = StLoadY;
      default: state_d = StLoadX;
    endcase
  end

  always_comb begin
    load_x_d       = 1'b0;
    load_y_d       = 1'b0;
    carry_d        = carry_q;
    result_d       = result_q;
    result_carry_d = result_carry_q;
    result_valid_d = result_valid_q;
    unique case (state_q)
      StLoadX: begin
        if (enter_q) load_x_d = 1'b1;
      end
      StLoadY: begin
        if (enter_q) begin
          load_y_d = 1'b1;
          carry_d  = carry_sel;
        end
      end
      StCalc: begin
        if (!load_y_q) begin
          result_d       = z_in;
          result_carry_d = carry_out_in;
          result_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (enter_q) begin
          result_valid_d = 1'b0;
          load_x_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign load_x         = load_x_q;
  assign load_y         = load_y_q;
  assign adder_carry_in = carry_q;
  assign result         = result_q;
  assign result_carry   = result_carry_q;
  assign result_valid   = result_valid_q;
  assign state          = state_q;

endmodule
